// File: rtl/crossbar_pkg.sv
// Shared definitions for the crossbar output-port arbiter: FSM state
// encoding, default port count and the per-crosspoint stream widths.
package crossbar_pkg;

    localparam int CB_PORTS_DEF = 8;
    localparam int CB_DATA_W    = 64;
    localparam int CB_KEEP_W    = 8;

    // Arbiter FSM: IDLE -> GRANT -> BUSY -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

    // One stream beat as seen on the selected crosspoint
    typedef struct packed {
        logic [CB_DATA_W-1:0] data;
        logic [CB_KEEP_W-1:0] keep;
        logic                 last;
    } beat_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: returns the first requesting index found
// when searching upward from rr_ptr, wrapping from P_PORTS-1 back to 0.
module rr_arbiter #(
    parameter int P_PORTS = crossbar_pkg::CB_PORTS_DEF
) (
    input  logic [P_PORTS-1:0]         req,
    input  logic [$clog2(P_PORTS)-1:0] rr_ptr,
    output logic [$clog2(P_PORTS)-1:0] winner,
    output logic                       any_req
);

    localparam int IW = $clog2(P_PORTS);

    int            pos;
    logic [IW-1:0] idx;

    // Scan all ports starting at rr_ptr; the first hit wins
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        pos     = 0;
        idx     = '0;
        for (int i = 0; i < P_PORTS; i++) begin
            pos = int'(rr_ptr) + i;
            if (pos >= P_PORTS) begin
                pos = pos - P_PORTS;
            end
            idx = IW'(pos);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

endmodule

// File: rtl/crossbar_out_arbiter.sv
// Output-port arbiter of a packet crossbar. Picks one requesting crosspoint
// round-robin, pulses its grant, then switches that crosspoint's AXI-Stream
// onto the output until the last beat is accepted.
// Optional watchdog: define CROSSBAR_ARB_TIMEOUT_EN to abandon an owner that
// goes P_TIMEOUT BUSY cycles without an accepted beat.
module crossbar_out_arbiter
    import crossbar_pkg::*;
#(
    parameter int P_PORTS   = CB_PORTS_DEF,
    parameter int P_TIMEOUT = 4096
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [P_PORTS-1:0]             i_trans_req,
    output logic [P_PORTS-1:0]             o_trans_grant,
    input  logic [P_PORTS-1:0]             s_axis_tvalid,
    input  logic [CB_DATA_W*P_PORTS-1:0]   s_axis_tdata,
    input  logic [P_PORTS-1:0]             s_axis_tlast,
    input  logic [CB_KEEP_W*P_PORTS-1:0]   s_axis_tkeep,
    output logic [P_PORTS-1:0]             s_axis_tready,
    output logic                           m_axis_tvalid,
    output logic [CB_DATA_W-1:0]           m_axis_tdata,
    output logic                           m_axis_tlast,
    output logic [CB_KEEP_W-1:0]           m_axis_tkeep,
    output logic                           m_axis_tuser,
    input  logic                           m_axis_tready,
    output logic                           o_busy,
    output logic [$clog2(P_PORTS)-1:0]     o_cur_port,
    output logic                           o_timeout
);

    localparam int IW = $clog2(P_PORTS);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      cur_port_q, cur_port_d;
    logic [P_PORTS-1:0] grant_q, grant_d;
    // Set when the last beat was already accepted during GRANT, so BUSY
    // closes the packet on its first cycle instead of waiting for another.
    logic               pkt_done_q, pkt_done_d;

    logic [IW-1:0]      winner;
    logic               any_req;
    logic               path_open;
    logic               sel_valid;
    beat_t              sel_beat;
    logic               beat_acc;
    logic               last_acc;
    logic               to_fire;
    logic [IW-1:0]      next_ptr;

    rr_arbiter #(
        .P_PORTS (P_PORTS)
    ) u_rr_arbiter (
        .req     (i_trans_req),
        .rr_ptr  (rr_ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    // The stream path is connected in GRANT and BUSY, except after the
    // packet has already completed inside GRANT.
    assign path_open = (state_q != ST_IDLE) && !pkt_done_q;

    // Select the owner's stream signals
    always_comb begin
        sel_valid     = s_axis_tvalid[cur_port_q];
        sel_beat.data = s_axis_tdata[cur_port_q*CB_DATA_W +: CB_DATA_W];
        sel_beat.keep = s_axis_tkeep[cur_port_q*CB_KEEP_W +: CB_KEEP_W];
        sel_beat.last = s_axis_tlast[cur_port_q];
    end

    assign m_axis_tvalid = path_open & sel_valid;
    assign m_axis_tdata  = path_open ? sel_beat.data : '0;
    assign m_axis_tkeep  = path_open ? sel_beat.keep : '0;
    assign m_axis_tlast  = path_open & sel_beat.last;
    assign m_axis_tuser  = 1'b0;

    // Only the owner sees downstream ready; non-owner beats are never taken
    always_comb begin
        s_axis_tready = '0;
        if (path_open) begin
            s_axis_tready[cur_port_q] = m_axis_tready;
        end
    end

    assign beat_acc = m_axis_tvalid & m_axis_tready;
    assign last_acc = beat_acc & m_axis_tlast;
    assign next_ptr = (cur_port_q == IW'(P_PORTS - 1)) ? '0 : cur_port_q + 1'b1;

`ifdef CROSSBAR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(P_TIMEOUT + 1);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          timeout_q, timeout_d;

    // Watchdog: count stalled BUSY cycles, restart on every accepted beat
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        to_fire  = 1'b0;
        if (state_q != ST_BUSY || pkt_done_q || beat_acc) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q == CW'(P_TIMEOUT - 1)) begin
            to_fire  = 1'b1;
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
        timeout_d = to_fire;
    end

    // Watchdog registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign to_fire   = 1'b0;
    // Always low; the compare only keeps P_TIMEOUT referenced in this build
    assign o_timeout = (P_TIMEOUT < 0);
`endif

    // Next-state logic of the arbitration FSM
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cur_port_d = cur_port_q;
        grant_d    = '0;
        pkt_done_d = pkt_done_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d         = ST_GRANT;
                    cur_port_d      = winner;
                    grant_d[winner] = 1'b1;
                    pkt_done_d      = 1'b0;
                end
            end
            ST_GRANT: begin
                state_d    = ST_BUSY;
                pkt_done_d = last_acc;
            end
            ST_BUSY: begin
                if (pkt_done_q || last_acc || to_fire) begin
                    state_d    = ST_IDLE;
                    rr_ptr_d   = next_ptr;
                    pkt_done_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            cur_port_q <= '0;
            grant_q    <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cur_port_q <= cur_port_d;
            grant_q    <= grant_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    assign o_trans_grant = grant_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_cur_port    = cur_port_q;

endmodule

// File: doc/crossbar_out_arbiter.md
CROSSBAR_OUT_ARBITER -- requirements
Module: crossbar_out_arbiter

Interface
REQ-001 SHALL have parameter P_PORTS, default 8: number of crosspoints feeding this output port.
REQ-002 SHALL have parameter P_TIMEOUT, default 4096: watchdog limit in cycles, used only under REQ-030.
REQ-003 SHALL have ports as below; one clock; reset asynchronous, active-low.
- i_clk  in  1  sole clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_trans_req  in  P_PORTS  per-crosspoint transmit request, level, held until granted.
- o_trans_grant  out  P_PORTS  one-hot grant pulse.
- s_axis_tvalid  in  P_PORTS  per-crosspoint stream valid.
- s_axis_tdata  in  64*P_PORTS  per-crosspoint data, port i at [64i+63:64i].
- s_axis_tlast  in  P_PORTS  per-crosspoint last beat.
- s_axis_tkeep  in  8*P_PORTS  per-crosspoint byte enables.
- s_axis_tready  out  P_PORTS  per-crosspoint ready.
- m_axis_tvalid  out  1  merged output valid.
- m_axis_tdata  out  64  merged output data.
- m_axis_tlast  out  1  merged output last.
- m_axis_tkeep  out  8  merged output keep.
- m_axis_tuser  out  1  tied 0.
- m_axis_tready  in  1  downstream ready.
- o_busy  out  1  high while a packet owns the output.
- o_cur_port  out  $clog2(P_PORTS)  index of the current owner.
- o_timeout  out  1  one-cycle watchdog pulse.

Function
REQ-010 SHALL implement the FSM IDLE -> GRANT -> BUSY -> IDLE.
REQ-011 SHALL, in IDLE with any i_trans_req bit high, select the winner round-robin, starting the search at rr_ptr and wrapping from P_PORTS-1 to 0.
REQ-012 SHALL enter GRANT on the next cycle with o_trans_grant[winner]=1 for exactly one cycle; latency from request to grant is 1 cycle.
REQ-013 SHALL latch the winner into o_cur_port on entry to GRANT, and hold it until return to IDLE.
REQ-014 SHALL always go from GRANT to BUSY after one cycle, and SHALL ignore all requests while in GRANT or BUSY.
REQ-015 SHALL, in GRANT and BUSY, drive m_axis_tvalid/tdata/tlast/tkeep combinationally from crosspoint o_cur_port.
REQ-016 SHALL, in GRANT and BUSY, drive s_axis_tready[o_cur_port]=m_axis_tready; all other s_axis_tready bits SHALL be 0.
REQ-017 SHALL, in IDLE, hold m_axis_tvalid=0 and all s_axis_tready bits=0.
REQ-018 SHALL discard any valid beats from non-owner crosspoints; they have no effect on outputs or state.
REQ-019 SHALL leave BUSY for IDLE on the cycle after m_axis_tvalid & m_axis_tready & m_axis_tlast.
REQ-020 SHALL set rr_ptr to (o_cur_port+1) mod P_PORTS on that same transition.
REQ-021 SHALL NOT grant in the cycle the FSM returns to IDLE with a request already pending; the earliest re-grant is 1 cycle after entering IDLE.
REQ-022 SHALL hold o_busy=1 in GRANT and BUSY, and 0 in IDLE.
REQ-023 SHALL give a single requester back-to-back grants, separated by IDLE and GRANT cycles.

Reset
REQ-025 SHALL, on i_rst_n low at any time including mid-packet, immediately force FSM=IDLE, rr_ptr=0, o_cur_port=0, o_trans_grant=0, o_busy=0 and o_timeout=0.
REQ-026 SHALL therefore, per REQ-017, hold m_axis_tvalid=0 and s_axis_tready=0 while in reset.
REQ-027 SHALL abandon any partial packet on reset; no recovery is attempted.

Configuration
REQ-030 SHALL, with macro CROSSBAR_ARB_TIMEOUT_EN defined, count BUSY cycles and clear the count on each accepted beat.
REQ-031 SHALL, when that count reaches P_TIMEOUT, pulse o_timeout for one cycle, return to IDLE and advance rr_ptr as in REQ-020.
REQ-032 SHALL, without CROSSBAR_ARB_TIMEOUT_EN, contain no counter and tie o_timeout to 0; BUSY then ends only per REQ-019.

Structure
REQ-040 SHALL take from shared package crossbar_pkg: the FSM state encoding (IDLE/GRANT/BUSY), P_PORTS default, the data width 64 and the keep width 8.
REQ-041 SHALL place the round-robin priority picker in sub-module rr_arbiter (inputs req vector and rr_ptr; outputs winner index and any_req).

Verification
REQ-050 SHALL cover single request: i_trans_req=8'h04 -> o_trans_grant=8'h04 for 1 cycle 1 cycle later, o_cur_port=2, a 5-beat packet passes unchanged, last tkeep=8'h0F preserved.
REQ-051 SHALL cover fairness: i_trans_req=8'hFF held, each packet 3 beats -> grant order 0,1,2,...,7,0.
REQ-052 SHALL cover backpressure: m_axis_tready toggled 1010 during a 4-beat packet -> s_axis_tready[owner] mirrors it, no beat lost or duplicated, FSM returns to IDLE only after the last beat is accepted.
REQ-053 SHALL cover isolation: a non-owner crosspoint drives tvalid during BUSY -> its tready=0 and m_axis output is unaffected.
REQ-054 SHALL cover reset mid-packet: i_rst_n low at beat 2 -> all outputs 0, rr_ptr=0, and the next request is granted normally.
REQ-055 SHALL cover timeout (macro on, P_TIMEOUT=16): the owner stalls with tvalid=0 -> o_timeout pulses after 16 cycles and the next requester is granted.
